// File: rtl/fetch_decode_unit.sv
// fetch_decode_unit: instruction-side responder to the control unit.
// Owns the PC, the instruction register and a circular return-address stack,
// and decodes the held instruction into fields for the control unit, the
// register file and the ALU.
// Optional feature macro: FETCH_BOUNDS_CHECK_EN (fetches beyond IMEM_WORDS
// latch a NOP and raise the sticky fetch_fault flag).
// PC_W is expected to exceed 24 so that the jump offset can be sign-extended.
module fetch_decode_unit #(
  parameter int PC_W       = 32,
  parameter int RESET_PC   = 0,
  parameter int RAS_DEPTH  = 8,
  parameter int IMEM_WORDS = 256
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            en_instruction_fetch,
  input  logic [1:0]      sig_pc_src,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_data,
  output logic [PC_W-1:0] pc,
  output logic [31:0]     instruction,
  output logic [1:0]      InstructionType,
  output logic [4:0]      FunctionCode,
  output logic            StopBit,
  output logic [3:0]      rd,
  output logic [3:0]      rs1,
  output logic [3:0]      rs2,
  output logic [15:0]     imm16,
  output logic [4:0]      sa,
  output logic            instruction_valid,
  output logic            ras_overflow,
  output logic            ras_underflow,
  output logic            fetch_fault
);

  localparam int SP_W  = $clog2(RAS_DEPTH);
  localparam int CNT_W = SP_W + 1;
  localparam logic [PC_W-1:0]  RESET_ADDR = PC_W'(RESET_PC);
  localparam logic [CNT_W-1:0] RAS_FULL   = CNT_W'(RAS_DEPTH);

  logic [31:0]      ir;
  logic             first_fetch;
  logic             en_q;
  logic [PC_W-1:0]  next_pc;
  logic [PC_W-1:0]  bta_off;
  logic [PC_W-1:0]  jta_off;
  logic [PC_W-1:0]  push_val;
  logic             fetch;
  logic             pop_req;
  logic             pop_ok;
  logic             push;
  logic             is_jal;
  logic             out_of_bounds;

  logic [PC_W-1:0]  ras_mem [RAS_DEPTH];
  logic [SP_W-1:0]  sp;
  logic [CNT_W-1:0] ras_count;
  logic             ras_empty;
  logic             ras_full;
  logic [PC_W-1:0]  ras_top;

  // A fetch happens only on the rising edge of the enable, so holding it
  // high performs exactly one fetch.
  assign fetch     = en_instruction_fetch & ~en_q;

  assign ras_empty = (ras_count == '0);
  assign ras_full  = (ras_count == RAS_FULL);
  assign ras_top   = ras_mem[sp];

  assign bta_off   = {{(PC_W-16){ir[16]}}, ir[16:1]};
  assign jta_off   = {{(PC_W-24){ir[24]}}, ir[24:1]};

  // The very first fetch after reset ignores the control unit's PC source
  // because there is no prior instruction to branch or return from.
  always_comb begin
    next_pc = pc + PC_W'(1);
    if (first_fetch) begin
      next_pc = RESET_ADDR;
    end else begin
      case (sig_pc_src)
        2'b01:   next_pc = pc + bta_off;
        2'b10:   next_pc = pc + jta_off;
        2'b11:   if (!ras_empty) next_pc = ras_top;
        default: next_pc = pc + PC_W'(1);
      endcase
    end
  end

  assign imem_addr = next_pc;
  assign push_val  = next_pc + PC_W'(1);
  assign is_jal    = (imem_data[26:25] == 2'b11) && (imem_data[31:27] == 5'b00001);
  assign pop_req   = fetch & ~first_fetch & (sig_pc_src == 2'b11);
  assign pop_ok    = pop_req & ~ras_empty;
  assign push      = fetch & is_jal & ~out_of_bounds;

`ifdef FETCH_BOUNDS_CHECK_EN
  localparam logic [PC_W:0] IMEM_LIMIT = (PC_W+1)'(IMEM_WORDS);

  assign out_of_bounds = ({1'b0, next_pc} >= IMEM_LIMIT);

  // Sticky record of any fetch that went past the end of instruction memory.
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_fault <= 1'b0;
    end else if (fetch && out_of_bounds) begin
      fetch_fault <= 1'b1;
    end
  end
`else
  assign out_of_bounds = 1'b0;
  assign fetch_fault   = 1'b0;
`endif

  // PC, instruction register and fetch bookkeeping; reset wins over a fetch.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc                <= RESET_ADDR;
      ir                <= '0;
      instruction_valid <= 1'b0;
      first_fetch       <= 1'b1;
      en_q              <= 1'b0;
    end else begin
      en_q <= en_instruction_fetch;
      if (fetch) begin
        pc                <= next_pc;
        ir                <= out_of_bounds ? 32'h0 : imem_data;
        instruction_valid <= 1'b1;
        first_fetch       <= 1'b0;
      end
    end
  end

  // Circular return-address stack: a push on full overwrites the oldest
  // entry, and a return that lands on a JAL replaces the top in place.
  always_ff @(posedge clock) begin
    if (reset) begin
      sp        <= '0;
      ras_count <= '0;
    end else if (push && pop_ok) begin
      ras_mem[sp] <= push_val;
    end else if (push) begin
      ras_mem[sp + SP_W'(1)] <= push_val;
      sp                     <= sp + SP_W'(1);
      if (!ras_full) ras_count <= ras_count + CNT_W'(1);
    end else if (pop_ok) begin
      sp        <= sp - SP_W'(1);
      ras_count <= ras_count - CNT_W'(1);
    end
  end

  // Sticky stack error flags, cleared only by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
    end else begin
      if (push && !pop_ok && ras_full) ras_overflow  <= 1'b1;
      if (pop_req && ras_empty)        ras_underflow <= 1'b1;
    end
  end

  assign instruction     = ir;
  assign InstructionType = ir[26:25];
  assign FunctionCode    = ir[31:27];
  assign StopBit         = ir[0];
  assign rd              = ir[24:21];
  assign rs1             = ir[20:17];
  assign rs2             = ir[16:13];
  assign imm16           = ir[16:1];
  assign sa              = ir[12:8];

endmodule

// File: tb/tb_fetch_decode_unit.sv
// tb_fetch_decode_unit: directed, table-driven bench for fetch_decode_unit
// with a small instruction memory model and hand-computed expected PCs.
module tb_fetch_decode_unit;

  logic        clock;
  logic        reset;
  logic        en_instruction_fetch;
  logic [1:0]  sig_pc_src;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic [1:0]  InstructionType;
  logic [4:0]  FunctionCode;
  logic        StopBit;
  logic [3:0]  rd;
  logic [3:0]  rs1;
  logic [3:0]  rs2;
  logic [15:0] imm16;
  logic [4:0]  sa;
  logic        instruction_valid;
  logic        ras_overflow;
  logic        ras_underflow;
  logic        fetch_fault;

  logic [31:0] imem [512];
  int numChecks;
  int numFails;

  typedef struct {
    logic [1:0]  src;
    int          hold;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic        exp_uf;
  } fetch_vec_t;

  fetch_vec_t vecs [16];

  fetch_decode_unit dut (
    .clock                (clock),
    .reset                (reset),
    .en_instruction_fetch (en_instruction_fetch),
    .sig_pc_src           (sig_pc_src),
    .imem_addr            (imem_addr),
    .imem_data            (imem_data),
    .pc                   (pc),
    .instruction          (instruction),
    .InstructionType      (InstructionType),
    .FunctionCode         (FunctionCode),
    .StopBit              (StopBit),
    .rd                   (rd),
    .rs1                  (rs1),
    .rs2                  (rs2),
    .imm16                (imm16),
    .sa                   (sa),
    .instruction_valid    (instruction_valid),
    .ras_overflow         (ras_overflow),
    .ras_underflow        (ras_underflow),
    .fetch_fault          (fetch_fault)
  );

  // Free-running clock, period 10.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Combinational instruction memory; addresses past the model read as 0.
  assign imem_data = (imem_addr < 32'd512) ? imem[imem_addr[8:0]] : 32'h0;

  // J-type word with a 24-bit relative jump offset in bits 24:1.
  function automatic logic [31:0] jword(input logic [4:0] fc, input int off);
    logic [23:0] o;
    o = off[23:0];
    return {fc, 2'b11, o, 1'b0};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    numChecks++;
    if (act !== exp) begin
      numFails++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Present a fetch request, check the combinational address, then hold the
  // enable for the requested cycles and return at the negedge after the fetch.
  task automatic applyStimulus(input logic [1:0] src, input int hold, input logic [31:0] exp_pc);
    @(negedge clock);
    en_instruction_fetch = 1'b1;
    sig_pc_src           = src;
    #1 checkOutput("imem_addr", imem_addr, exp_pc);
    repeat (hold) @(negedge clock);
    en_instruction_fetch = 1'b0;
  endtask

  task automatic checkFetch(input logic [31:0] exp_pc, input logic [31:0] exp_instr);
    checkOutput("pc", pc, exp_pc);
    checkOutput("instruction", instruction, exp_instr);
    checkOutput("instruction_valid", {31'b0, instruction_valid}, 32'd1);
  endtask

  task automatic doFetch(input logic [1:0] src, input logic [31:0] exp_pc);
    applyStimulus(src, 1, exp_pc);
    checkFetch(exp_pc, imem[exp_pc[8:0]]);
  endtask

  task automatic doReset();
    @(negedge clock);
    reset                = 1'b1;
    en_instruction_fetch = 1'b0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    numChecks            = 0;
    numFails             = 0;
    reset                = 1'b0;
    en_instruction_fetch = 1'b0;
    sig_pc_src           = 2'b00;

    for (int k = 0; k < 512; k++) imem[k] = 32'hA000_0000 | k;
    imem[0]  = 32'h0;
    imem[1]  = jword(5'b00010, 99);
    imem[2]  = jword(5'b00010, 198);
    imem[3]  = jword(5'b00010, 252);
    imem[8]  = jword(5'b00010, 12);
    imem[10] = 32'h1C01_FFFC;
    imem[20] = jword(5'b00001, 10);
    for (int k = 100; k <= 116; k += 2) imem[k] = jword(5'b00001, 2);
    imem[200] = jword(5'b00001, 5);
    imem[201] = jword(5'b00001, 10);

    vecs[0]  = '{2'b10, 1, 32'd0,  32'h0, 1'b0};
    vecs[1]  = '{2'b00, 1, 32'd1,  32'h0, 1'b0};
    vecs[2]  = '{2'b00, 1, 32'd2,  32'h0, 1'b0};
    vecs[3]  = '{2'b00, 1, 32'd3,  32'h0, 1'b0};
    vecs[4]  = '{2'b00, 1, 32'd4,  32'h0, 1'b0};
    vecs[5]  = '{2'b00, 5, 32'd5,  32'h0, 1'b0};
    vecs[6]  = '{2'b00, 1, 32'd6,  32'h0, 1'b0};
    vecs[7]  = '{2'b00, 1, 32'd7,  32'h0, 1'b0};
    vecs[8]  = '{2'b00, 1, 32'd8,  32'h0, 1'b0};
    vecs[9]  = '{2'b00, 1, 32'd9,  32'h0, 1'b0};
    vecs[10] = '{2'b00, 1, 32'd10, 32'h0, 1'b0};
    vecs[11] = '{2'b01, 1, 32'd8,  32'h0, 1'b0};
    vecs[12] = '{2'b10, 1, 32'd20, 32'h0, 1'b0};
    vecs[13] = '{2'b10, 1, 32'd30, 32'h0, 1'b0};
    vecs[14] = '{2'b11, 1, 32'd21, 32'h0, 1'b0};
    vecs[15] = '{2'b11, 1, 32'd22, 32'h0, 1'b1};
    for (int i = 0; i < 16; i++) vecs[i].exp_instr = imem[vecs[i].exp_pc[8:0]];

    // Reset state; the first fetch address ignores the PC source.
    doReset();
    sig_pc_src = 2'b11;
    #1;
    checkOutput("reset pc", pc, 32'd0);
    checkOutput("reset instruction", instruction, 32'h0);
    checkOutput("reset valid", {31'b0, instruction_valid}, 32'd0);
    checkOutput("reset imem_addr", imem_addr, 32'd0);
    checkOutput("reset flags", {29'b0, ras_overflow, ras_underflow, fetch_fault}, 32'd0);

    // Main walk: first fetch, held enable, branch back, JAL and returns.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].src, vecs[i].hold, vecs[i].exp_pc);
      checkFetch(vecs[i].exp_pc, vecs[i].exp_instr);
      checkOutput("ras_underflow", {31'b0, ras_underflow}, {31'b0, vecs[i].exp_uf});
      if (i == 10) begin
        checkOutput("InstructionType", {30'b0, InstructionType}, 32'd2);
        checkOutput("FunctionCode", {27'b0, FunctionCode}, 32'd3);
        checkOutput("imm16", {16'b0, imm16}, 32'h0000_FFFE);
        checkOutput("rd/rs1/rs2", {20'b0, rd, rs1, rs2}, 32'h0000_000F);
        checkOutput("sa/StopBit", {26'b0, sa, StopBit}, 32'h0000_003E);
      end
    end

    // Idle cycles must not move the PC.
    repeat (3) @(negedge clock);
    checkOutput("idle pc hold", pc, 32'd22);

    // Nine nested JALs overflow an eight-entry stack; nine returns underflow.
    doReset();
    doFetch(2'b10, 32'd0);
    doFetch(2'b00, 32'd1);
    for (int k = 0; k < 9; k++) begin
      doFetch(2'b10, 32'd100 + 32'(2 * k));
      checkOutput("nest overflow", {31'b0, ras_overflow}, {31'b0, (k == 8)});
    end
    for (int r = 0; r < 8; r++) begin
      doFetch(2'b11, 32'd117 - 32'(2 * r));
      checkOutput("return underflow", {31'b0, ras_underflow}, 32'd0);
    end
    doFetch(2'b11, 32'd104);
    checkOutput("ninth return underflow", {31'b0, ras_underflow}, 32'd1);

    // Return landing on a JAL replaces the top without changing the count.
    doReset();
    doFetch(2'b10, 32'd0);
    doFetch(2'b00, 32'd1);
    doFetch(2'b00, 32'd2);
    doFetch(2'b10, 32'd200);
    doFetch(2'b10, 32'd205);
    doFetch(2'b11, 32'd201);
    checkOutput("swap flags", {30'b0, ras_overflow, ras_underflow}, 32'd0);
    doFetch(2'b11, 32'd202);
    checkOutput("swap pop flags", {30'b0, ras_overflow, ras_underflow}, 32'd0);
    doFetch(2'b11, 32'd203);
    checkOutput("swap empty underflow", {31'b0, ras_underflow}, 32'd1);

    // Fetch across the end of instruction memory.
    doReset();
    doFetch(2'b10, 32'd0);
    doFetch(2'b00, 32'd1);
    doFetch(2'b00, 32'd2);
    doFetch(2'b00, 32'd3);
    doFetch(2'b10, 32'd255);
    checkOutput("fault at 255", {31'b0, fetch_fault}, 32'd0);
    applyStimulus(2'b00, 1, 32'd256);
`ifdef FETCH_BOUNDS_CHECK_EN
    checkFetch(32'd256, 32'h0);
    checkOutput("fault at 256", {31'b0, fetch_fault}, 32'd1);
`else
    checkFetch(32'd256, imem[256]);
    checkOutput("fault at 256", {31'b0, fetch_fault}, 32'd0);
`endif

    // Reset asserted on a fetch edge wins.
    @(negedge clock);
    reset                = 1'b1;
    en_instruction_fetch = 1'b1;
    sig_pc_src           = 2'b00;
    @(negedge clock);
    checkOutput("reset-wins pc", pc, 32'd0);
    checkOutput("reset-wins valid", {31'b0, instruction_valid}, 32'd0);
    checkOutput("reset-wins instruction", instruction, 32'h0);
    checkOutput("reset-wins fault", {31'b0, fetch_fault}, 32'd0);
    reset                = 1'b0;
    en_instruction_fetch = 1'b0;
    @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
